// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache/burst-memory definitions for the line-to-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BURST_WIDTH = 64;
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_WIDTH   = $clog2(BEATS);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam addr_t ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  // Bit position of a beat inside a line; beat 0 is the least significant.
  function automatic int unsigned beat_lsb(input cnt_t c);
    return 32'(c) * BURST_WIDTH;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts a 256-bit cache line read/write into a 4-beat 64-bit memory burst.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  line_address,
  input  logic                   line_read,
  input  logic                   line_write,
  input  logic [LINE_WIDTH-1:0]  line_wdata,
  output logic [LINE_WIDTH-1:0]  line_rdata,
  output logic                   line_resp,
  output logic [ADDR_WIDTH-1:0]  bmem_address,
  output logic                   bmem_read,
  output logic                   bmem_write,
  output logic [BURST_WIDTH-1:0] bmem_wdata,
  input  logic [BURST_WIDTH-1:0] bmem_rdata,
  input  logic                   bmem_resp
);

  localparam cnt_t LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  state_e r_state;
  state_e w_state_next;
  cnt_t   r_cnt;
  cnt_t   w_cnt_inc;
  logic   w_last;
  line_t  r_buf;
  line_t  w_buf_merged;
  line_t  r_rdata;
  addr_t  r_addr;
  beat_t  r_wdata;
  logic   r_bmem_read;
  logic   r_bmem_write;
  logic   r_line_resp;

  assign w_cnt_inc = CNT_WIDTH'(r_cnt + 1'b1);
  assign w_last    = bmem_resp && (r_cnt == LAST_BEAT);

  // Next-state logic; write has priority over read when both are requested.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (line_write)     w_state_next = ST_WRITE;
        else if (line_read) w_state_next = ST_READ;
      end
      ST_READ:  if (w_last) w_state_next = ST_DONE;
      ST_WRITE: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Line buffer with the current read beat inserted at the counter position.
  always_comb begin
    w_buf_merged = r_buf;
    w_buf_merged[beat_lsb(r_cnt) +: BURST_WIDTH] = bmem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Datapath: address/line capture, beat counter, and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_buf        <= '0;
      r_rdata      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_line_resp  <= 1'b0;
    end else begin
      r_bmem_read  <= (w_state_next == ST_READ);
      r_bmem_write <= (w_state_next == ST_WRITE);
      r_line_resp  <= (w_state_next == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          if (line_write) begin
            r_addr  <= line_address & ALIGN_MASK;
            r_buf   <= line_wdata;
            r_wdata <= line_wdata[BURST_WIDTH-1:0];
            r_cnt   <= '0;
          end else if (line_read) begin
            r_addr <= line_address & ALIGN_MASK;
            r_cnt  <= '0;
          end
        end
        ST_READ: begin
          if (bmem_resp) begin
            r_buf <= w_buf_merged;
            r_cnt <= w_last ? '0 : w_cnt_inc;
            if (w_last) r_rdata <= w_buf_merged;
          end
        end
        ST_WRITE: begin
          if (bmem_resp) begin
            r_cnt   <= w_last ? '0 : w_cnt_inc;
            r_wdata <= r_buf[beat_lsb(w_cnt_inc) +: BURST_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign line_rdata   = r_rdata;
  assign line_resp    = r_line_resp;
  assign bmem_address = r_addr;
  assign bmem_read    = r_bmem_read;
  assign bmem_write   = r_bmem_write;
  assign bmem_wdata   = r_wdata;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for the cache line to burst memory adaptor.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] line_address;
  logic        line_read;
  logic        line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic        line_resp;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;

  int checks = 0;
  int failures = 0;
  logic [255:0] last_rdata = '0;
  logic [255:0] mem [logic [31:0]];

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_address(line_address), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           g0, g1, g2, g3;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One full line transfer: idle cycle, request, four beats with the given gaps, DONE.
  // For a read, exp_line is both the memory content beats and the expected assembled line.
  // For a write, exp_line is the line written and beat b must equal exp_line[64*b +: 64].
  task automatic run_burst(input string name, input bit is_wr, input bit also_rd, input bit keep_rd,
                           input logic [31:0] addr, input logic [255:0] exp_line,
                           input logic [31:0] exp_addr, input int g0, input int g1,
                           input int g2, input int g3);
    int gaps [4];
    gaps = '{g0, g1, g2, g3};
    step();
    chk({name, "/idle_resp"}, 256'(line_resp), 256'(0));
    chk({name, "/idle_rd"}, 256'(bmem_read), 256'(0));
    chk({name, "/idle_wr"}, 256'(bmem_write), 256'(0));
    line_address = addr;
    line_write   = is_wr;
    line_read    = !is_wr || also_rd;
    line_wdata   = is_wr ? exp_line : rnd_line();
    step();
    line_address = $urandom;
    line_wdata   = rnd_line();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k <= gaps[b]; k++) begin
        chk({name, "/bmem_read"}, 256'(bmem_read), 256'(!is_wr));
        chk({name, "/bmem_write"}, 256'(bmem_write), 256'(is_wr));
        chk({name, "/bmem_address"}, 256'(bmem_address), 256'(exp_addr));
        chk({name, "/early_resp"}, 256'(line_resp), 256'(0));
        if (is_wr) chk({name, "/bmem_wdata"}, 256'(bmem_wdata), 256'(exp_line[b*64 +: 64]));
        if (k == gaps[b]) begin
          bmem_resp  = 1'b1;
          bmem_rdata = exp_line[b*64 +: 64];
        end else begin
          bmem_resp  = 1'b0;
          bmem_rdata = {$urandom, $urandom};
        end
        step();
      end
    end
    bmem_resp = 1'b0;
    chk({name, "/line_resp"}, 256'(line_resp), 256'(1));
    chk({name, "/done_rd"}, 256'(bmem_read), 256'(0));
    chk({name, "/done_wr"}, 256'(bmem_write), 256'(0));
    if (!is_wr) last_rdata = exp_line;
    chk({name, "/line_rdata"}, line_rdata, last_rdata);
    line_write = 1'b0;
    line_read  = keep_rd;
  endtask

  vec_t vecs [3];

  initial begin
    vecs[0] = '{"rd_contig", 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                0, 0, 0, 0, 32'h0000_1220,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{"wr_contig", 1'b1, 32'h2000_005F,
                {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
                0, 1, 0, 3, 32'h2000_0040,
                {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}};
    vecs[2] = '{"rd_stall", 1'b0, 32'hABCD_EF1F,
                {64'hCAFE_F00D_0000_0004, 64'hBEEF_0000_0000_0003,
                 64'hFACE_0000_0000_0002, 64'hA5A5_5A5A_0000_0001},
                0, 2, 5, 1, 32'hABCD_EF00,
                {64'hCAFE_F00D_0000_0004, 64'hBEEF_0000_0000_0003,
                 64'hFACE_0000_0000_0002, 64'hA5A5_5A5A_0000_0001}};

    rst = 1'b0;
    line_address = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    bmem_rdata = '0; bmem_resp = 1'b0;
    step(); step();
    chk("rst/line_resp", 256'(line_resp), 256'(0));
    chk("rst/bmem_read", 256'(bmem_read), 256'(0));
    chk("rst/bmem_write", 256'(bmem_write), 256'(0));
    chk("rst/bmem_address", 256'(bmem_address), 256'(0));
    chk("rst/bmem_wdata", 256'(bmem_wdata), 256'(0));
    chk("rst/line_rdata", line_rdata, 256'(0));
    rst = 1'b1;

    // Stray beat strobes while idle must not start anything or move the counter.
    for (int i = 0; i < 3; i++) begin
      bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
      step();
      chk("idle_resp/line_resp", 256'(line_resp), 256'(0));
      chk("idle_resp/bmem_read", 256'(bmem_read), 256'(0));
    end
    bmem_resp = 1'b0;

    for (int v = 0; v < 3; v++) begin
      run_burst(vecs[v].name, vecs[v].is_wr, 1'b0, 1'b0, vecs[v].addr, vecs[v].line,
                vecs[v].exp_addr, vecs[v].g0, vecs[v].g1, vecs[v].g2, vecs[v].g3);
      if (!vecs[v].is_wr) chk({vecs[v].name, "/exp_line"}, line_rdata, vecs[v].exp_line);
    end

    // Both requests together: write first, then the still-held read.
    run_burst("both_wr", 1'b1, 1'b1, 1'b1, 32'h0000_0047, rnd_line(), 32'h0000_0040, 0, 0, 0, 0);
    run_burst("held_rd", 1'b0, 1'b0, 1'b0, 32'h0000_0047, rnd_line(), 32'h0000_0040, 0, 0, 0, 0);

    // Reset after two beats of a read aborts without a completion.
    step();
    line_address = 32'h0000_8888; line_read = 1'b1;
    step();
    line_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
      step();
    end
    bmem_resp = 1'b0;
    chk("abort/pre_rd", 256'(bmem_read), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("abort/bmem_read", 256'(bmem_read), 256'(0));
    chk("abort/bmem_address", 256'(bmem_address), 256'(0));
    chk("abort/line_rdata", line_rdata, 256'(0));
    chk("abort/line_resp", 256'(line_resp), 256'(0));
    last_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      bmem_resp = 1'b1;
      step();
      chk("abort/held_resp", 256'(line_resp), 256'(0));
    end
    bmem_resp = 1'b0;
    rst = 1'b1;
    run_burst("after_rst", 1'b0, 1'b0, 1'b0, 32'h0000_8888, rnd_line(), 32'h0000_8880, 1, 0, 2, 0);

    // Random traffic against a line-granular memory model.
    for (int n = 0; n < 30; n++) begin
      logic [31:0]  a;
      logic [31:0]  base;
      logic [255:0] ln;
      bit           wr;
      wr   = ($urandom % 2) == 1;
      a    = 32'h8000_0000 + $urandom_range(0, 3) * 32 + $urandom_range(0, 31);
      base = a - (a % 32);
      if (wr) begin
        ln = rnd_line();
        mem[base] = ln;
      end else begin
        ln = mem.exists(base) ? mem[base] : rnd_line();
      end
      run_burst("rand", wr, 1'b0, 1'b0, a, ln, base,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    step();
    chk("final/line_resp", 256'(line_resp), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
